// File: rtl/filt_sched.sv
// filt_sched: sample scheduler/sequencer in front of the filters datapath.
// Buffers one non-stallable XADC sample, runs the start/done handshake with
// the datapath, applies filter-select changes only between samples, and
// suppresses results while the tap history is stale after a select change.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   s_valid, s_data  incoming sample strobe and value (always accepted)
//   sel_req          requested filter: 00 LPF, 01 HPF, 10 BPF, 11 bypass
//   filt_start       start level to the datapath (held until done)
//   filt_select      select applied to the datapath
//   filt_val         sample presented to the datapath
//   filt_done        datapath done (sampled only while busy)
//   filt_result      datapath result
//   m_valid, m_data  single-cycle result strobe and filtered value
//   settled          warm-up complete for the current select
//   drop_cnt         saturating count of overwritten samples
//   timeout_err      sticky busy watchdog flag
//
// Optional build macro FILT_SCHED_TIMEOUT_EN adds a busy watchdog of
// TIMEOUT_CYCLES cycles; without it timeout_err is tied low.
module filt_sched #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned M              = 211,
    parameter int unsigned DROP_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        sel_req,
    output logic              filt_start,
    output logic [1:0]        filt_select,
    output logic [DATA_W-1:0] filt_val,
    input  logic              filt_done,
    input  logic [DATA_W-1:0] filt_result,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              settled,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              timeout_err
);

    localparam int unsigned WARM_W  = $clog2(M + 1);
    localparam logic [1:0]  SEL_BYP = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic                start_q, start_d;
    logic [1:0]          select_q, select_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic                settled_q, settled_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                issue;

`ifdef FILT_SCHED_TIMEOUT_EN
    localparam int unsigned BUSY_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic                tmo_q, tmo_d;
`endif

    // Reject a watchdog limit that could never be reached.
    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("filt_sched: TIMEOUT_CYCLES must be non-zero");
    end

    // Buffered sample leaves for the datapath this cycle.
    assign issue = (state_q == IDLE) && buf_full_q;

    // Next-state and register update logic.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        start_d    = start_q;
        select_d   = select_q;
        val_d      = val_q;
        res_d      = res_q;
        m_valid_d  = 1'b0;
        m_data_d   = m_data_q;
        warm_d     = warm_q;
        drop_d     = drop_q;
`ifdef FILT_SCHED_TIMEOUT_EN
        busy_cnt_d = busy_cnt_q;
        tmo_d      = tmo_q;
`endif

        // One-entry buffer: a new sample always wins; it is a drop only if
        // the old one was not handed to the datapath in the same cycle.
        if (s_valid) begin
            buf_d      = s_data;
            buf_full_d = 1'b1;
            if (buf_full_q && !issue && (drop_q != '1)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (issue) begin
            buf_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    val_d    = buf_q;
                    select_d = sel_req;
                    start_d  = 1'b1;
                    state_d  = BUSY;
                    // New select invalidates the tap history; bypass has none.
                    if (sel_req != select_q) begin
                        warm_d = (sel_req == SEL_BYP) ? '0 : WARM_W'(M);
                    end
`ifdef FILT_SCHED_TIMEOUT_EN
                    busy_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (filt_done) begin
                    res_d   = filt_result;
                    start_d = 1'b0;
                    state_d = DONE;
                end
`ifdef FILT_SCHED_TIMEOUT_EN
                else if (busy_cnt_q == BUSY_W'(TIMEOUT_CYCLES - 1)) begin
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                    warm_d  = (select_q == SEL_BYP) ? '0 : WARM_W'(M);
                end else begin
                    busy_cnt_d = busy_cnt_q + BUSY_W'(1);
                end
`endif
            end
            DONE: begin
                if (warm_q == '0) begin
                    m_valid_d = 1'b1;
                    m_data_d  = res_q;
                end else begin
                    warm_d = warm_q - WARM_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        settled_d = (warm_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            start_q    <= 1'b0;
            select_q   <= 2'b00;
            val_q      <= '0;
            res_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            warm_q     <= WARM_W'(M);
            settled_q  <= 1'b0;
            drop_q     <= '0;
`ifdef FILT_SCHED_TIMEOUT_EN
            busy_cnt_q <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            start_q    <= start_d;
            select_q   <= select_d;
            val_q      <= val_d;
            res_q      <= res_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            warm_q     <= warm_d;
            settled_q  <= settled_d;
            drop_q     <= drop_d;
`ifdef FILT_SCHED_TIMEOUT_EN
            busy_cnt_q <= busy_cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign filt_start  = start_q;
    assign filt_select = select_q;
    assign filt_val    = val_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign settled     = settled_q;
    assign drop_cnt    = drop_q;
`ifdef FILT_SCHED_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched with M=4, TIMEOUT_CYCLES=16: directed scenarios plus
// randomized single-sample transactions against a transaction-level model.
module tb_filt_sched;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned M      = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        sel_req;
    logic              filt_start;
    logic [1:0]        filt_select;
    logic [DATA_W-1:0] filt_val;
    logic              filt_done;
    logic [DATA_W-1:0] filt_result;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              settled;
    logic [DROP_W-1:0] drop_cnt;
    logic              timeout_err;

    int vectors = 0;
    int errors  = 0;

    filt_sched #(
        .DATA_W(DATA_W), .M(M), .DROP_W(DROP_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .sel_req(sel_req), .filt_start(filt_start), .filt_select(filt_select),
        .filt_val(filt_val), .filt_done(filt_done), .filt_result(filt_result),
        .m_valid(m_valid), .m_data(m_data), .settled(settled),
        .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: done after dly cycles of start, bypass always done.
    int   dly = 0;
    int   busy_cyc = 0;
    logic hold_low = 1'b0;
    always @(posedge clk) begin
        if (!filt_start) busy_cyc <= 0;
        else             busy_cyc <= busy_cyc + 1;
    end
    assign filt_done   = (filt_select == 2'b11) ||
                         (filt_start && !hold_low && (busy_cyc >= dly));
    assign filt_result = (filt_select == 2'b11) ? filt_val
                         : DATA_W'(filt_val + 16'd1 + 16'(filt_select));

    // Collect every result strobe.
    logic [DATA_W-1:0] obs_q[$];
    always @(negedge clk) begin
        if (rstn === 1'b1 && m_valid === 1'b1) obs_q.push_back(m_data);
    end

    function automatic logic [DATA_W-1:0] model_f(input logic [DATA_W-1:0] x,
                                                  input logic [1:0] sel);
        return (sel == 2'b11) ? x : DATA_W'(x + 16'd1 + 16'(sel));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_start(input logic lvl, input string tag);
        int n = 0;
        while (filt_start !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(filt_start), 32'(lvl));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [DATA_W-1:0] smp[6];
        logic [DATA_W-1:0] a_s, e_s, x_s, y_s, p_s, q_s, d;
        logic [1:0]        m_sel, sel;
        int                m_warm, n;
        bit                exp_out;

        rstn = 1'b0; s_valid = 1'b0; s_data = '0; sel_req = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start",   32'(filt_start), 0);
        chk("rst_select",  32'(filt_select), 0);
        chk("rst_val",     32'(filt_val), 0);
        chk("rst_mvalid",  32'(m_valid), 0);
        chk("rst_mdata",   32'(m_data), 0);
        chk("rst_settled", 32'(settled), 0);
        chk("rst_drop",    32'(drop_cnt), 0);
        chk("rst_tmo",     32'(timeout_err), 0);
        rstn = 1'b1;

        // Bypass: one-cycle start, result 3 cycles after the sample
        sel_req = 2'b11;
        send(16'h1234);
        chk("byp_start_pre", 32'(filt_start), 0);
        @(negedge clk);
        chk("byp_start_hi", 32'(filt_start), 1);
        chk("byp_select",   32'(filt_select), 3);
        @(negedge clk);
        chk("byp_start_lo", 32'(filt_start), 0);
        @(negedge clk);
        chk("byp_mvalid",  32'(m_valid), 1);
        chk("byp_mdata",   32'(m_data), 32'h1234);
        chk("byp_settled", 32'(settled), 1);
        @(negedge clk);
        chk("byp_mvalid_pulse", 32'(m_valid), 0);

        // LPF warm-up: first M results suppressed
        sel_req = 2'b00; dly = 5; obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            smp[i] = DATA_W'($urandom);
            send(smp[i]);
            repeat (19) @(negedge clk);
            if (i == 0) chk("lpf_mdata_hold", 32'(m_data), 32'h1234);
            if (i == 2) chk("lpf_settled_3", 32'(settled), 0);
            if (i == 3) chk("lpf_settled_4", 32'(settled), 1);
        end
        chk("lpf_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("lpf_res5", 32'(obs_q[0]), 32'(DATA_W'(smp[4] + 16'd1)));
            chk("lpf_res6", 32'(obs_q[1]), 32'(DATA_W'(smp[5] + 16'd1)));
        end

        // Overrun: B..E arrive while A is busy, E survives
        dly = 50; obs_q.delete();
        a_s = DATA_W'($urandom);
        e_s = DATA_W'($urandom);
        send(a_s);
        for (int i = 0; i < 4; i++) begin
            repeat (9) @(negedge clk);
            send((i == 3) ? e_s : DATA_W'($urandom));
        end
        chk("ovr_drop", 32'(drop_cnt), 3);
        wait_start(1'b0, "ovr_a_done");
        wait_start(1'b1, "ovr_e_issue");
        chk("ovr_e_val", 32'(filt_val), 32'(e_s));
        repeat (70) @(negedge clk);
        chk("ovr_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("ovr_res_a", 32'(obs_q[0]), 32'(DATA_W'(a_s + 16'd1)));
            chk("ovr_res_e", 32'(obs_q[1]), 32'(DATA_W'(e_s + 16'd1)));
        end

        // Select change during BUSY takes effect at the next issue
        dly = 5; obs_q.delete();
        x_s = DATA_W'($urandom);
        y_s = DATA_W'($urandom);
        send(x_s);
        wait_start(1'b1, "sel_x_issue");
        sel_req = 2'b01;
        repeat (2) @(negedge clk);
        chk("sel_hold_busy", 32'(filt_select), 0);
        wait_start(1'b0, "sel_x_done");
        chk("sel_hold_done", 32'(filt_select), 0);
        repeat (10) @(negedge clk);
        chk("sel_x_count", obs_q.size(), 1);
        if (obs_q.size() == 1) chk("sel_x_res", 32'(obs_q[0]), 32'(DATA_W'(x_s + 16'd1)));
        send(y_s);
        wait_start(1'b1, "sel_y_issue");
        chk("sel_new",     32'(filt_select), 1);
        chk("sel_y_val",   32'(filt_val), 32'(y_s));
        chk("sel_settled", 32'(settled), 0);
        repeat (20) @(negedge clk);
        chk("sel_y_suppressed", obs_q.size(), 1);

        // Reset mid-life clears drop count; then back-to-back samples
        do_reset();
        chk("rst2_drop",    32'(drop_cnt), 0);
        chk("rst2_settled", 32'(settled), 0);
        rstn = 1'b1;
        sel_req = 2'b11; obs_q.delete();
        p_s = DATA_W'($urandom);
        q_s = DATA_W'($urandom);
        @(negedge clk); s_valid = 1'b1; s_data = p_s;
        @(negedge clk); s_data = q_s;
        @(negedge clk); s_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("sim_drop",  32'(drop_cnt), 0);
        chk("sim_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("sim_res_p", 32'(obs_q[0]), 32'(p_s));
            chk("sim_res_q", 32'(obs_q[1]), 32'(q_s));
        end

        // Randomized isolated transactions vs warm-up model
        m_sel = 2'b11; m_warm = 0;
        for (int i = 0; i < 24; i++) begin
            sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : m_sel;
            d   = DATA_W'($urandom);
            dly = $urandom_range(0, 6);
            sel_req = sel; obs_q.delete();
            send(d);
            repeat (20) @(negedge clk);
            if (sel != m_sel) begin
                m_warm = (sel == 2'b11) ? 0 : M;
                m_sel  = sel;
            end
            exp_out = (m_warm == 0);
            if (!exp_out) m_warm--;
            chk("rnd_select",  32'(filt_select), 32'(sel));
            chk("rnd_count",   obs_q.size(), exp_out ? 1 : 0);
            if (exp_out && obs_q.size() == 1)
                chk("rnd_data", 32'(obs_q[0]), 32'(model_f(d, sel)));
            chk("rnd_settled", 32'(settled), (m_warm == 0) ? 1 : 0);
        end

`ifdef FILT_SCHED_TIMEOUT_EN
        // Watchdog: start drops after 16 busy cycles, no result
        sel_req = 2'b00; hold_low = 1'b1; obs_q.delete();
        send(DATA_W'($urandom));
        wait_start(1'b1, "wd_issue");
        n = 0;
        while (filt_start === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wd_busy_len", n, 16);
        chk("wd_err", 32'(timeout_err), 1);
        repeat (5) @(negedge clk);
        chk("wd_no_result", obs_q.size(), 0);
        chk("wd_err_sticky", 32'(timeout_err), 1);
        hold_low = 1'b0;
        do_reset();
        chk("wd_err_cleared", 32'(timeout_err), 0);
        rstn = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
